// File: rtl/toa_mult_sequencer_if.sv
// toa_mult_sequencer_if: operand/product handshakes plus the shared three-operand adder port.
interface toa_mult_sequencer_if #(
  parameter int WIDTH = 7,
  parameter int ADD_W = 14
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ADD_W-1:0] out_prod;
  logic             out_ovf;
  logic [ADD_W-1:0] add_a;
  logic [ADD_W-1:0] add_b;
  logic [ADD_W-1:0] add_c;
  logic             add_cin;
  logic [ADD_W:0]   add_sum;
  logic             add_carry;
  modport master (
    input  in_valid, in_a, in_b, out_ready, add_sum, add_carry,
    output in_ready, out_valid, out_prod, out_ovf, add_a, add_b, add_c, add_cin
  );
  modport slave (
    output in_valid, in_a, in_b, out_ready, add_sum, add_carry,
    input  in_ready, out_valid, out_prod, out_ovf, add_a, add_b, add_c, add_cin
  );
endinterface

// File: rtl/toa_mult_sequencer.sv
// toa_mult_sequencer: sequential WIDTH x WIDTH multiplier driving an external three-operand adder.
// Define TOA_APPROX_TRUNC_EN to zero the low TRUNC_K bits of every partial product (approximate mode).
module toa_mult_sequencer #(
  parameter int WIDTH   = 7,
  parameter int ADD_W   = 14,
  parameter int TRUNC_K = 2
) (
  input logic                   clk,
  input logic                   rst,
  toa_mult_sequencer_if.master  bus
);
  localparam int NP = (WIDTH + 1) / 2;
  localparam int CW = NP > 1 ? $clog2(NP) : 1;
`ifdef TOA_APPROX_TRUNC_EN
  localparam logic [ADD_W-1:0] PP_MASK = ~((ADD_W'(1) << TRUNC_K) - ADD_W'(1));
`else
  localparam logic [ADD_W-1:0] PP_MASK = '1;
`endif
  generate
    if (ADD_W != 2 * WIDTH) begin : g_bad_w
      $error("ADD_W must equal 2*WIDTH");
    end
    if (TRUNC_K < 0 || TRUNC_K > WIDTH - 1) begin : g_bad_k
      $error("TRUNC_K must lie in 0..WIDTH-1");
    end
  endgenerate
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [ADD_W-1:0] acc_q, acc_d, prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, oovf_q, oovf_d, valid_q, valid_d;
  logic             run;
  // Shifting b right makes bit j read as 0 once j runs past the operand width.
  function automatic logic [ADD_W-1:0] pp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic [CW:0] j);
    logic [WIDTH-1:0] bs;
    bs = b >> j;
    return bs[0] ? (ADD_W'(a) << j) & PP_MASK : '0;
  endfunction
  assign run           = state_q == RUN;
  assign bus.in_ready  = !rst && state_q == IDLE;
  assign bus.add_a     = run ? acc_q : '0;
  assign bus.add_b     = run ? pp(a_q, b_q, {cnt_q, 1'b0}) : '0;
  assign bus.add_c     = run ? pp(a_q, b_q, {cnt_q, 1'b1}) : '0;
  assign bus.add_cin   = 1'b0;
  assign bus.out_valid = valid_q;
  assign bus.out_prod  = prod_q;
  assign bus.out_ovf   = oovf_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    prod_d  = prod_q;
    oovf_d  = oovf_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: if (bus.in_valid && bus.in_ready) begin
        a_d     = bus.in_a;
        b_d     = bus.in_b;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        acc_d = bus.add_sum[ADD_W-1:0];
        ovf_d = ovf_q | bus.add_sum[ADD_W] | bus.add_carry;
        cnt_d = CW'(cnt_q + 1'b1);
        if (cnt_q == CW'(NP - 1)) begin
          prod_d  = bus.add_sum[ADD_W-1:0];
          oovf_d  = ovf_d;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (bus.out_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      prod_q  <= '0;
      oovf_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      prod_q  <= prod_d;
      oovf_q  <= oovf_d;
      valid_q <= valid_d;
    end
  end
endmodule
